// File: rtl/data_ram_responder_pkg.sv
// Shared types for the data RAM responder: reset polarity, FSM states,
// word geometry constants and a byte-lane mask helper.
package data_ram_responder_pkg;

    typedef logic reset_status_t;

    localparam reset_status_t RST_ENABLE  = 1'b1;
    localparam reset_status_t RST_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_WAIT,
        MEM_RESP
    } mem_state_t;

    localparam int         WORD_BYTES = 4;
    localparam logic [3:0] SEL_ALL    = 4'b1111;

    // Expand the 4 byte-lane enables into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/data_ram_array.sv
// DEPTH_WORDS x 32 storage: synchronous byte-lane write, combinational read.
// Ports: clk, we (write enable), sel (lane enables), index (word), wdata, rdata.
module data_ram_array
    import data_ram_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [3:0]                     sel,
    input  logic [$clog2(DEPTH_WORDS)-1:0] index,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] mask;

    assign mask  = lane_mask(sel);
    assign rdata = mem[index];

    // No reset: contents survive a pipeline reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= (mem[index] & ~mask) | (wdata & mask);
        end
    end

endmodule

// File: rtl/data_ram_responder.sv
// Word-addressed data memory answering load/store requests with a
// configurable number of wait states and a one-cycle ready pulse.
// Ports: clk, rst (async high), req_i/we_i/addr_i/sel_i/wdata_i request,
//        rdata_o/ready_o/err_o response, busy_o stall indication.
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic          clk,
    input  reset_status_t rst,
    input  logic          req_i,
    input  logic          we_i,
    input  logic [31:0]   addr_i,
    input  logic [3:0]    sel_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o,
    output logic          ready_o,
    output logic          err_o,
    output logic          busy_o
);

    localparam int IW = $clog2(DEPTH_WORDS);

    mem_state_t  state;
    logic [3:0]  cnt;

    logic        txn_we;
    logic [3:0]  txn_sel;
    logic [31:0] txn_wdata;
    logic        txn_err;
    logic [IW-1:0] txn_index;

    logic [31:0] offset;
    logic        in_range;
    logic        req_err;
    logic [31:0] ram_rdata;
    logic        ram_we;

    // Addresses below BASE_ADDR wrap to a huge offset, so a single
    // "no bits above the array span" test covers both range limits.
    assign offset   = addr_i - BASE_ADDR;
    assign in_range = (offset >> (IW + 2)) == 32'd0;
    assign req_err  = (addr_i[1:0] != 2'b00) || !in_range;

    assign ram_we = (state == MEM_RESP) && txn_we && !txn_err;
    assign busy_o = (state == MEM_WAIT) || (state == MEM_RESP);

    data_ram_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .we   (ram_we),
        .sel  (txn_sel),
        .index(txn_index),
        .wdata(txn_wdata),
        .rdata(ram_rdata)
    );

    // Request payload is captured in IDLE and needs no reset.
    always_ff @(posedge clk) begin
        if (state == MEM_IDLE && req_i) begin
            txn_we    <= we_i;
            txn_sel   <= sel_i;
            txn_wdata <= wdata_i;
            txn_err   <= req_err;
            txn_index <= offset[IW+1:2];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state   <= MEM_IDLE;
            cnt     <= 4'd0;
            ready_o <= 1'b0;
            err_o   <= 1'b0;
            rdata_o <= 32'd0;
        end else begin
            ready_o <= 1'b0;
            err_o   <= 1'b0;
            rdata_o <= 32'd0;
            unique case (state)
                MEM_IDLE: begin
                    if (req_i) begin
                        if (WAIT_CYCLES == 0) begin
                            state <= MEM_RESP;
                        end else begin
                            cnt   <= 4'(WAIT_CYCLES - 1);
                            state <= MEM_WAIT;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= MEM_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                MEM_RESP: begin
                    ready_o <= 1'b1;
                    err_o   <= txn_err;
                    if (!txn_we && !txn_err) begin
                        rdata_o <= ram_rdata & lane_mask(txn_sel);
                    end
                    state <= MEM_IDLE;
                end
                default: state <= MEM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_ram_responder.sv
// Bench for data_ram_responder: three instances (2, 0 and 15 wait states)
// checked against a word-array reference model.
module tb_data_ram_responder;
    import data_ram_responder_pkg::*;

    localparam int NI = 3;
    localparam int WC0 = 2;
    localparam int WC1 = 0;
    localparam int WC2 = 15;
    localparam int D0 = 64;
    localparam int D1 = 16;
    localparam int D2 = 64;
    localparam logic [31:0] B0 = 32'h0000_0000;
    localparam logic [31:0] B1 = 32'h0000_0000;
    localparam logic [31:0] B2 = 32'h0000_1000;

    logic          clk = 1'b1;
    reset_status_t rst;
    logic          req   [NI];
    logic          we    [NI];
    logic [31:0]   addr  [NI];
    logic [3:0]    sel   [NI];
    logic [31:0]   wdata [NI];
    logic [31:0]   rdata [NI];
    logic          ready [NI];
    logic          err   [NI];
    logic          busy  [NI];

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] mdl [NI][64];

    always #5 clk = ~clk;

    data_ram_responder #(.DEPTH_WORDS(D0), .WAIT_CYCLES(WC0), .BASE_ADDR(B0)) u0 (
        .clk(clk), .rst(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
        .sel_i(sel[0]), .wdata_i(wdata[0]), .rdata_o(rdata[0]),
        .ready_o(ready[0]), .err_o(err[0]), .busy_o(busy[0]));

    data_ram_responder #(.DEPTH_WORDS(D1), .WAIT_CYCLES(WC1), .BASE_ADDR(B1)) u1 (
        .clk(clk), .rst(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
        .sel_i(sel[1]), .wdata_i(wdata[1]), .rdata_o(rdata[1]),
        .ready_o(ready[1]), .err_o(err[1]), .busy_o(busy[1]));

    data_ram_responder #(.DEPTH_WORDS(D2), .WAIT_CYCLES(WC2), .BASE_ADDR(B2)) u2 (
        .clk(clk), .rst(rst), .req_i(req[2]), .we_i(we[2]), .addr_i(addr[2]),
        .sel_i(sel[2]), .wdata_i(wdata[2]), .rdata_o(rdata[2]),
        .ready_o(ready[2]), .err_o(err[2]), .busy_o(busy[2]));

    function automatic int wc_of(input int k);
        case (k)
            0:       return WC0;
            1:       return WC1;
            default: return WC2;
        endcase
    endfunction

    function automatic int depth_of(input int k);
        case (k)
            0:       return D0;
            1:       return D1;
            default: return D2;
        endcase
    endfunction

    function automatic logic [31:0] base_of(input int k);
        case (k)
            0:       return B0;
            1:       return B1;
            default: return B2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed range/alignment rules applied to a word array.
    task automatic model(input int k, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d,
                         output logic e, output logic [31:0] r);
        longint off;
        int     i;
        off = longint'(a) - longint'(base_of(k));
        e   = (a[1:0] != 2'b00) || (off < 0) || (off >= 4 * depth_of(k));
        r   = 32'd0;
        if (!e) begin
            i = int'(off / 4);
            for (int b = 0; b < 4; b++) begin
                if (s[b]) begin
                    if (w) mdl[k][i][8*b +: 8] = d[8*b +: 8];
                    else   r[8*b +: 8] = mdl[k][i][8*b +: 8];
                end
            end
        end
    endtask

    task automatic txn(input int k, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d,
                       input bit scramble, input string tag,
                       output logic [31:0] got_r, output logic got_e);
        logic        ee;
        logic [31:0] er;
        int          n;
        model(k, w, a, s, d, ee, er);
        @(negedge clk);
        req[k] = 1'b1; we[k] = w; addr[k] = a; sel[k] = s; wdata[k] = d;
        @(posedge clk); #1;
        chk({tag, "_busy_on"}, 32'(busy[k]), 32'd1);
        n = 0;
        while (!ready[k] && n < 40) begin
            if (scramble) begin
                req[k]  = 1'($urandom);
                addr[k] = $urandom | 32'd1;
                we[k]   = ~w;
            end
            @(posedge clk); #1;
            n++;
        end
        req[k] = 1'b0;
        got_r = rdata[k];
        got_e = err[k];
        chk({tag, "_latency"}, 32'(n), 32'(wc_of(k) + 1));
        chk({tag, "_err"}, 32'(err[k]), 32'(ee));
        if (!w) chk({tag, "_rdata"}, rdata[k], er);
        chk({tag, "_busy_off"}, 32'(busy[k]), 32'd0);
    endtask

    initial begin
        logic [31:0] gr;
        logic        ge;
        logic [31:0] old;
        logic [31:0] er;
        logic        ee;
        logic [31:0] a;
        int          kind;

        rst = RST_ENABLE;
        for (int k = 0; k < NI; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'd0;
            sel[k] = 4'd0; wdata[k] = 32'd0;
        end

        // Reset held for 195 ns; outputs must stay quiet.
        repeat (19) begin
            @(negedge clk);
            chk("rst_ready", {29'd0, ready[0], ready[1], ready[2]}, 32'd0);
            chk("rst_busy", {29'd0, busy[0], busy[1], busy[2]}, 32'd0);
            chk("rst_rdata", rdata[0] | rdata[1] | rdata[2], 32'd0);
        end
        @(negedge clk);
        rst = RST_DISABLE;

        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < depth_of(k); i++) begin
                txn(k, 1'b1, base_of(k) + 32'(4 * i), SEL_ALL, $urandom, 1'b0,
                    "fill", gr, ge);
            end
        end

        // Reset in the middle of a store's wait phase abandons it.
        old = mdl[0][4];
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10;
        sel[0] = SEL_ALL; wdata[0] = ~old;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = RST_ENABLE;
        #1;
        chk("midrst_ready", 32'(ready[0]), 32'd0);
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        chk("midrst_rdata", rdata[0], 32'd0);
        @(negedge clk);
        rst = RST_DISABLE;
        req[0] = 1'b0;
        txn(0, 1'b0, 32'h10, SEL_ALL, 32'd0, 1'b0, "midrst_load", gr, ge);
        chk("midrst_old", gr, old);

        // Store/load and byte lanes.
        txn(0, 1'b1, 32'h8, 4'hF, 32'hDEAD_BEEF, 1'b0, "st8", gr, ge);
        txn(0, 1'b0, 32'h8, 4'hF, 32'd0, 1'b0, "ld8", gr, ge);
        chk("ld8_val", gr, 32'hDEAD_BEEF);
        chk("ld8_noerr", 32'(ge), 32'd0);
        txn(0, 1'b1, 32'h8, 4'b0010, 32'h0000_5500, 1'b0, "stlane", gr, ge);
        txn(0, 1'b0, 32'h8, 4'hF, 32'd0, 1'b0, "ldlane", gr, ge);
        chk("ldlane_val", gr, 32'hDEAD_55EF);
        txn(0, 1'b0, 32'h8, 4'b0001, 32'd0, 1'b0, "ldb0", gr, ge);
        chk("ldb0_val", gr, 32'h0000_00EF);
        txn(0, 1'b0, 32'h8, 4'b0000, 32'd0, 1'b0, "ldsel0", gr, ge);
        chk("ldsel0_val", gr, 32'd0);

        // Errors.
        txn(0, 1'b0, 32'h6, 4'hF, 32'd0, 1'b0, "mis", gr, ge);
        chk("mis_err", 32'(ge), 32'd1);
        chk("mis_rdata", gr, 32'd0);
        old = mdl[0][0];
        txn(0, 1'b1, B0 + 32'(4 * D0), 4'hF, ~old, 1'b0, "oor", gr, ge);
        chk("oor_err", 32'(ge), 32'd1);
        txn(0, 1'b0, B0, 4'hF, 32'd0, 1'b0, "w0", gr, ge);
        chk("w0_keep", gr, old);
        txn(2, 1'b0, B2 - 32'd4, 4'hF, 32'd0, 1'b0, "below", gr, ge);
        chk("below_err", 32'(ge), 32'd1);

        // Back-to-back with req held, zero wait states.
        model(1, 1'b0, 32'h14, SEL_ALL, 32'd0, ee, er);
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h14; sel[1] = SEL_ALL;
        @(posedge clk); #1;
        for (int n = 0; n < 8; n++) begin
            chk("b2b_ready", 32'(ready[1]), 32'(n % 2));
            chk("b2b_busy", 32'(busy[1]), 32'((n + 1) % 2));
            if (n % 2 == 1) chk("b2b_rdata", rdata[1], er);
            @(posedge clk); #1;
        end
        req[1] = 1'b0;
        @(posedge clk); #1;
        chk("b2b_last", 32'(ready[1]), 32'd1);

        // Fifteen wait states with request inputs disturbed during WAIT.
        txn(2, 1'b1, B2 + 32'h20, 4'b1010, $urandom, 1'b1, "w15_st", gr, ge);
        txn(2, 1'b0, B2 + 32'h20, 4'hF, 32'd0, 1'b1, "w15_ld", gr, ge);

        // Random mix of valid, misaligned and out-of-range accesses.
        for (int k = 0; k < NI; k++) begin
            for (int t = 0; t < 25; t++) begin
                kind = int'($urandom_range(0, 3));
                a = base_of(k) + 32'(4 * $urandom_range(0, depth_of(k) - 1));
                if (kind == 2) a = a + 32'($urandom_range(1, 3));
                if (kind == 3) a = base_of(k) + 32'(4 * depth_of(k))
                                   + 32'(4 * $urandom_range(0, 15));
                txn(k, 1'($urandom), a, 4'($urandom), $urandom, 1'b0,
                    "rnd", gr, ge);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/data_ram_responder.md
Name: data_ram_responder

Overview:
- Word-addressed data memory that answers load/store requests from the OpenMIPS memory stage over a req/ready handshake.
- Wait-state latency is configurable, so the pipeline's stall path is exercised.
- Instantiated inside openmips_min_sopc next to the instruction ROM, on the same clk/rst.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 4.
- WAIT_CYCLES, 2, cycles spent in WAIT before a response; 0..15 allowed.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  reset_status_t (1)  asynchronous, active-high reset; RST_ENABLE = asserted.
- req_i  in  1  request valid; held high with stable inputs until ready_o is seen.
- we_i  in  1  1 = store, 0 = load.
- addr_i  in  32  byte address.
- sel_i  in  4  byte lane enables; bit0 = data[7:0].
- wdata_i  in  32  store data.
- rdata_o  out  32  load data; valid only while ready_o = 1.
- ready_o  out  1  one-cycle completion pulse.
- err_o  out  1  qualifies ready_o; access was misaligned or out of range.
- busy_o  out  1  high in WAIT and RESP; feeds the stall controller.

Behaviour:
- Reset, asynchronous on rst = RST_ENABLE:
  - state = IDLE; ready_o = 0, err_o = 0, busy_o = 0, rdata_o = 0; wait counter = 0.
  - Storage contents are not cleared.
  - A transaction in flight at reset is abandoned; a pending store is not written.
- States are IDLE, WAIT and RESP (mem_state_t).
- IDLE:
  - When req_i = 1, latch we/addr/sel/wdata and compute the error flag.
  - Error = addr_i[1:0] != 0, or addr_i outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS).
  - If WAIT_CYCLES = 0, go to RESP; otherwise load counter = WAIT_CYCLES - 1 and go to WAIT.
  - When req_i = 0, stay in IDLE.
- WAIT:
  - Decrement the counter each cycle; go to RESP in the cycle after the counter reads 0.
  - req_i is ignored while in WAIT.
- RESP, exactly one cycle:
  - ready_o = 1 and err_o = latched error flag.
  - Store without error: write the lanes whose sel bit is 1 on this edge; other lanes keep their value.
  - Load without error: rdata_o = stored word with unselected lanes forced to 0; sel = 0 returns 0.
  - Any error: no write, rdata_o = 0.
  - Next state is always IDLE.
- Latency from the req_i sampling edge to ready_o is WAIT_CYCLES + 1 cycles.
- Back-to-back requests leave a one-cycle IDLE bubble, so the minimum period is WAIT_CYCLES + 2 cycles.
- A load issued right after a store to the same word returns the new data, because the write commits in RESP before the next IDLE.
- Word index = (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits after the range check; no wrap-around aliasing.
- ready_o, err_o and rdata_o are registered outputs.
- busy_o is decoded from state only.

Decomposition:
- Add to project_types:
  - mem_state_t enum {MEM_IDLE, MEM_WAIT, MEM_RESP};
  - constants WORD_BYTES = 4 and SEL_ALL = 4'b1111.
- Reuse the existing reset_status_t and RST_ENABLE/RST_DISABLE.
- Sub-module data_ram_array: synchronous byte-lane-write, combinational-read storage (DEPTH_WORDS x 32).
  - Ports: clk, we, sel, index, wdata, rdata.
  - No reset.
- The FSM, counter and range check stay in data_ram_responder.

Test Plan:
1. Reset: assert rst for 195 ns, then release. Expect ready_o = 0, busy_o = 0, rdata_o = 0 throughout. Assert rst mid-WAIT of a store to 0x10, then read 0x10; old value returned, store not written.
2. Store then load, WAIT_CYCLES = 2: store 0x8 with 0xDEADBEEF, sel 4'hF. ready_o appears 3 cycles after req is sampled. The following load of 0x8 returns 0xDEADBEEF with err_o = 0.
3. Byte lanes: word 0x8 = 0xDEADBEEF; store sel 4'b0010, wdata 0x0000_5500. A full load returns 0xDEAD55EF; a load with sel 4'b0001 returns 0x0000_00EF.
4. Errors: load 0x6 (misaligned) -> ready_o = 1, err_o = 1, rdata_o = 0. Store to BASE_ADDR + 4*DEPTH_WORDS -> err_o = 1 and word 0 is unchanged.
5. Back-to-back with req_i held high, WAIT_CYCLES = 0: ready_o pulses every 2 cycles, and busy_o alternates 1,0.
6. WAIT_CYCLES = 15: ready_o arrives exactly 16 cycles after sampling. Changing req_i and addr_i during WAIT has no effect on the response.
